// File: rtl/seq_prog.sv
// Program store and instruction fetch stage feeding the sequencer.
// A host appends instructions during Load. Run then returns store[next] one cycle later
// and halts once the fetch address leaves the loaded program.
module seq_prog #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned INST_WIDTH = 12,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [INST_WIDTH-1:0] load_data,
  input  logic                  load_wen,
  input  logic                  load_done,
  input  logic                  run,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] next,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_wen,
  output logic [ADDR_WIDTH:0]   length,
  output logic                  overflow,
  output logic                  halted,
  output logic                  ready
);

  localparam logic [1:0] StLoad  = 2'd0;
  localparam logic [1:0] StReady = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  localparam logic [ADDR_WIDTH:0] FullLen = (ADDR_WIDTH + 1)'(DEPTH);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   length_q, length_d;
  logic                  overflow_q, overflow_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  inst_wen_q, inst_wen_d;
  logic                  halted_q, halted_d;
  logic                  mem_we;
  logic                  fetch;

  logic [INST_WIDTH-1:0] mem_q [DEPTH];

  // Next-state logic: clear overrides everything; fetch is shared by Ready and Run.
  always_comb begin
    state_d    = state_q;
    length_d   = length_q;
    overflow_d = overflow_q;
    inst_d     = inst_q;
    inst_wen_d = 1'b0;
    halted_d   = halted_q;
    mem_we     = 1'b0;
    fetch      = 1'b0;
    if (clear) begin
      state_d    = StLoad;
      length_d   = '0;
      overflow_d = 1'b0;
      inst_d     = '0;
      halted_d   = 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          if (load_wen) begin
            if (length_q == FullLen) begin
              overflow_d = 1'b1;
            end else begin
              mem_we   = 1'b1;
              length_d = length_q + 1'b1;
            end
          end
          if (load_done) state_d = StReady;
        end
        // The edge that sees run in Ready already performs the first fetch.
        StReady: fetch = run;
        StRun:   fetch = run;
        StHalt:  inst_d = '0;
        default: state_d = StLoad;
      endcase
      if (fetch) begin
        if ({1'b0, next} < length_q) begin
          inst_d     = mem_q[next];
          inst_wen_d = 1'b1;
          state_d    = StRun;
        end else begin
          inst_d   = '0;
          halted_d = 1'b1;
          state_d  = StHalt;
        end
      end
    end
  end

  // Control and output registers, asynchronously cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StLoad;
      length_q   <= '0;
      overflow_q <= 1'b0;
      inst_q     <= '0;
      inst_wen_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      length_q   <= length_d;
      overflow_q <= overflow_d;
      inst_q     <= inst_d;
      inst_wen_q <= inst_wen_d;
      halted_q   <= halted_d;
    end
  end

  // Program store write port; contents are not reset.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[length_q[ADDR_WIDTH-1:0]] <= load_data;
  end

  assign inst     = inst_q;
  assign inst_wen = inst_wen_q;
  assign length   = length_q;
  assign overflow = overflow_q;
  assign halted   = halted_q;
  assign ready    = (state_q == StReady) || (state_q == StRun);

endmodule

// File: tb/tb_seq_prog.sv
// Self-checking bench for seq_prog: directed steps plus randomized programs and fetches,
// compared against a queue-based model of the program store.
module tb_seq_prog;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] load_data = '0;
  logic        load_wen = 1'b0;
  logic        load_done = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  next = '0;
  logic [11:0] inst;
  logic        inst_wen;
  logic [8:0]  length;
  logic        overflow;
  logic        halted;
  logic        ready;

  seq_prog dut (
    .clock    (clock),
    .reset    (reset),
    .load_data(load_data),
    .load_wen (load_wen),
    .load_done(load_done),
    .run      (run),
    .clear    (clear),
    .next     (next),
    .inst     (inst),
    .inst_wen (inst_wen),
    .length   (length),
    .overflow (overflow),
    .halted   (halted),
    .ready    (ready)
  );

  always #5 clock = ~clock;

  localparam int MLoad  = 0;
  localparam int MReady = 1;
  localparam int MRun   = 2;
  localparam int MHalt  = 3;

  int checks = 0;
  int failures = 0;
  int stepno = 0;

  // Reference model: the loaded program is simply a queue of words.
  logic [11:0] prog[$];
  int          m_mode;
  logic [11:0] m_inst;
  logic        m_wen;
  logic        m_halted;
  logic        m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepno, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("inst", 32'(inst), 32'(m_inst));
    chk("inst_wen", 32'(inst_wen), 32'(m_wen));
    chk("length", 32'(length), 32'(prog.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("ready", 32'(ready), 32'((m_mode == MReady) || (m_mode == MRun)));
  endtask

  task automatic model_reset();
    prog.delete();
    m_mode   = MLoad;
    m_inst   = '0;
    m_wen    = 1'b0;
    m_halted = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // One clock: drive at negedge, update model, check at the following negedge.
  task automatic step(input logic lw, input logic [11:0] d, input logic ldn, input logic rn,
                      input logic clr, input logic [7:0] nx);
    load_wen  = lw;
    load_data = d;
    load_done = ldn;
    run       = rn;
    clear     = clr;
    next      = nx;
    stepno++;
    m_wen = 1'b0;
    if (clr) begin
      prog.delete();
      m_mode   = MLoad;
      m_ovf    = 1'b0;
      m_inst   = '0;
      m_halted = 1'b0;
    end else if (m_mode == MLoad) begin
      if (lw) begin
        if (prog.size() == 256) m_ovf = 1'b1;
        else prog.push_back(d);
      end
      if (ldn) m_mode = MReady;
    end else if (m_mode == MHalt) begin
      m_inst = '0;
    end else if (rn) begin
      if (int'(nx) < prog.size()) begin
        m_inst = prog[nx];
        m_wen  = 1'b1;
        m_mode = MRun;
      end else begin
        m_inst   = '0;
        m_halted = 1'b1;
        m_mode   = MHalt;
      end
    end
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  initial begin
    int n;
    logic [7:0] nx;
    model_reset();
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b1;
    @(negedge clock);

    // Load 3 words, run 0,1, pause 4 cycles, resume at 2, then halt at 3.
    step(1, 12'h101, 0, 0, 0, 0);
    step(1, 12'h305, 0, 0, 0, 0);
    step(1, 12'h000, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(1, 12'h555, 0, 0, 0, 0);  // ignored in Ready
    step(0, 0, 0, 1, 0, 0);
    chk("plan_inst0", 32'(inst), 32'h101);
    step(0, 0, 0, 1, 0, 1);
    chk("plan_inst1", 32'(inst), 32'h305);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 8'(2 + i));
    chk("pause_hold", 32'(inst), 32'h305);
    step(1, 12'hABC, 0, 1, 0, 2);
    chk("plan_inst2", 32'(inst), 32'h000);
    chk("plan_wen2", 32'(inst_wen), 32'h1);
    step(0, 0, 0, 1, 0, 3);
    chk("halt_flag", 32'(halted), 32'h1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1'($urandom), 0, 8'($urandom));

    // Clear has priority over load_wen in Halt; then reload one word.
    step(1, 12'h123, 0, 0, 1, 0);
    chk("clear_len", 32'(length), 32'h0);
    step(1, 12'h7AA, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("clear_inst", 32'(inst), 32'h7AA);

    // Empty program halts on the first run cycle.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("empty_halt", 32'(halted), 32'h1);

    // Full store, overflow write coinciding with load_done, never halts.
    step(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 256; i++) step(1, 12'(i), 0, 0, 0, 0);
    step(1, 12'hFFF, 1, 0, 0, 0);
    chk("full_len", 32'(length), 32'd256);
    chk("full_ovf", 32'(overflow), 32'h1);
    step(0, 0, 0, 1, 0, 8'd255);
    chk("full_last", 32'(inst), 32'h0FF);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1'($urandom_range(0, 3) != 0), 0, 8'($urandom));

    // Random programs and fetch patterns.
    for (int p = 0; p < 4; p++) begin
      step(0, 0, 0, 0, 1, 0);
      n = $urandom_range(0, 20);
      for (int i = 0; i < n; i++) step(1, 12'($urandom), 0, 0, 0, 0);
      step(1'($urandom), 12'($urandom), 1, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
        nx = 8'($urandom_range(0, n + 2));
        step(1'($urandom), 12'($urandom), 0, 1'($urandom_range(0, 3) != 0), 0, nx);
      end
    end

    // Asynchronous reset while inst_wen is high.
    step(0, 0, 0, 0, 1, 0);
    step(1, 12'h456, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("pre_rst_wen", 32'(inst_wen), 32'h1);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clock);
    reset = 1'b1;
    step(1, 12'h321, 0, 0, 0, 0);
    chk("post_rst_len", 32'(length), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
